// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle sequencer for the mini MIPS datapath. Each instruction is stepped
// through FETCH / DECODE / EXEC / MEM / WB. The sequencer drives the datapath
// strobes one phase at a time. It waits on the instruction and data memory
// handshakes, flags illegal opcodes and memory timeouts, and counts retired
// instructions.
//
// Parameters
//   TIMEOUT : max wait cycles in FETCH or MEM before ERR (0 = never time out)
//   CNT_W   : width of o_retired_cnt
//
// Ports
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_run               : level, start/continue issuing instructions
//   i_opcode[3:0]       : IR[15:12], sampled in DECODE
//   i_imem_ready        : instruction word available this cycle
//   i_dmem_ready        : data access completes this cycle
//   o_imem_req, o_dmem_req, o_ir_write, o_pc_write : fetch / memory strobes
//   o_reg_dest, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
//   o_alu_src, o_alu_op[2:0], o_branch_eq, o_branch_not_eq : datapath controls
//   o_busy, o_err, o_retire, o_retired_cnt : status
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [3:0]       i_opcode,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_reg_dest,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_mem_to_reg,
    output logic             o_alu_src,
    output logic [2:0]       o_alu_op,
    output logic             o_branch_eq,
    output logic             o_branch_not_eq,
    output logic             o_busy,
    output logic             o_err,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    localparam logic [3:0] OP_R   = 4'b0000;
    localparam logic [3:0] OP_BEQ = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_op;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_wait_clr;
    logic                w_wait_inc;
    logic                w_timeout;

    // Opcodes 1010..1111 are unassigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3] & (op[2] | op[1]);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        logic [2:0] v;
        case (op)
            4'b0000:          v = 3'b000;
            4'b0001:          v = 3'b001;
            4'b0010:          v = 3'b110;
            4'b0011:          v = 3'b011;
            4'b0100:          v = 3'b100;
            4'b0101, 4'b0110: v = 3'b010;
            4'b0111:          v = 3'b111;
            4'b1000, 4'b1001: v = 3'b001;
            default:          v = 3'b000;
        endcase
        return v;
    endfunction

    // A ready arriving in the same cycle as the limit is checked first, so it wins.
    assign w_timeout = (TIMEOUT != 32'd0) && (r_wait == TIMEOUT_V);

    // State, latched opcode, wait counter and retire counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_op    <= 4'b0000;
            r_wait  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= i_opcode;
            end
            if (w_wait_clr) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
            if (o_retire) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and strobe decode; retire chooses FETCH or IDLE from run.
    always_comb begin
        w_next          = r_state;
        w_wait_clr      = 1'b0;
        w_wait_inc      = 1'b0;
        o_imem_req      = 1'b0;
        o_dmem_req      = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_reg_dest      = 1'b0;
        o_reg_write     = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_alu_src       = 1'b0;
        o_alu_op        = 3'b000;
        o_branch_eq     = 1'b0;
        o_branch_not_eq = 1'b0;
        o_retire        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_next     = S_FETCH;
                    w_wait_clr = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_illegal(i_opcode)) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                o_alu_op  = alu_op_of(r_op);
                o_alu_src = !((r_op == OP_R) || (r_op == OP_BEQ) || (r_op == OP_BNE));
                if ((r_op == OP_BEQ) || (r_op == OP_BNE)) begin
                    o_branch_eq     = (r_op == OP_BEQ);
                    o_branch_not_eq = (r_op == OP_BNE);
                    o_retire        = 1'b1;
                end else if ((r_op == OP_LW) || (r_op == OP_SW)) begin
                    w_next     = S_MEM;
                    w_wait_clr = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                o_dmem_req  = 1'b1;
                o_mem_read  = (r_op == OP_LW);
                o_mem_write = (r_op == OP_SW);
                o_alu_op    = 3'b001;
                if (i_dmem_ready) begin
                    if (r_op == OP_SW) begin
                        o_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WB: begin
                o_reg_write  = 1'b1;
                o_reg_dest   = (r_op == OP_R);
                o_mem_to_reg = (r_op == OP_LW);
                o_retire     = 1'b1;
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
        if (o_retire) begin
            if (i_run) begin
                w_next     = S_FETCH;
                w_wait_clr = 1'b1;
            end else begin
                w_next = S_IDLE;
            end
        end else begin
            w_next = w_next;
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_err         = (r_state == S_ERR);
    assign o_retired_cnt = r_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, ir_write, pc_write, reg_dest, reg_write;
    logic        mem_read, mem_write, mem_to_reg, alu_src;
    logic [2:0]  alu_op;
    logic        branch_eq, branch_not_eq, busy, err, retire;
    logic [15:0] retired_cnt;

    int n_vec = 0;
    int n_mis = 0;
    int exp_cnt = 0;

    mips_multicycle_ctrl #(.TIMEOUT(15), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_opcode(opcode),
        .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
        .o_imem_req(imem_req), .o_dmem_req(dmem_req), .o_ir_write(ir_write),
        .o_pc_write(pc_write), .o_reg_dest(reg_dest), .o_reg_write(reg_write),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg),
        .o_alu_src(alu_src), .o_alu_op(alu_op), .o_branch_eq(branch_eq),
        .o_branch_not_eq(branch_not_eq), .o_busy(busy), .o_err(err),
        .o_retire(retire), .o_retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    wire [14:0] strobes = {imem_req, dmem_req, ir_write, pc_write, reg_dest, reg_write,
                           mem_read, mem_write, mem_to_reg, alu_src, alu_op,
                           branch_eq, branch_not_eq, retire};

    typedef struct {
        logic [3:0] op;
        int iw; int dw; int lat;
        logic [2:0] alu; logic src;
        int rw; int mr; int mw; int beq; int bne;
        logic m2r; logic rd;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Issue one instruction from IDLE with run dropped after FETCH entry.
    task automatic run_vec(input int idx, input vec_t v);
        int fw = 0, dw = 0, lat = -1, n_ir = 0, n_pc = 0;
        int n_rw = 0, n_mr = 0, n_mw = 0, n_be = 0, n_bn = 0;
        int ex_alu = -1, ex_src = -1, m2r = 0, rd = 0;
        bit got = 1'b0;
        @(negedge clk);
        run = 1'b1; opcode = v.op; imem_ready = 1'b0; dmem_ready = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            run = 1'b0;
            imem_ready = imem_req && (fw >= v.iw);
            dmem_ready = dmem_req && (dw >= v.dw);
            #1;
            if (imem_req && !imem_ready) fw++;
            if (dmem_req && !dmem_ready) dw++;
            n_ir += int'(ir_write); n_pc += int'(pc_write);
            n_rw += int'(reg_write); n_mr += int'(mem_read); n_mw += int'(mem_write);
            n_be += int'(branch_eq); n_bn += int'(branch_not_eq);
            if (c == 3 + v.iw) begin ex_alu = int'(alu_op); ex_src = int'(alu_src); end
            if (reg_write) begin m2r |= int'(mem_to_reg); rd |= int'(reg_dest); end
            if (retire) begin got = 1'b1; lat = c; end
        end
        exp_cnt++;
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d alu_op", idx), ex_alu, int'(v.alu));
        chk($sformatf("v%0d alu_src", idx), ex_src, int'(v.src));
        chk($sformatf("v%0d ir_write", idx), n_ir, 1);
        chk($sformatf("v%0d pc_write", idx), n_pc, 1);
        chk($sformatf("v%0d reg_write", idx), n_rw, v.rw);
        chk($sformatf("v%0d mem_read", idx), n_mr, v.mr);
        chk($sformatf("v%0d mem_write", idx), n_mw, v.mw);
        chk($sformatf("v%0d branch_eq", idx), n_be, v.beq);
        chk($sformatf("v%0d branch_not_eq", idx), n_bn, v.bne);
        chk($sformatf("v%0d mem_to_reg", idx), m2r, int'(v.m2r));
        chk($sformatf("v%0d reg_dest", idx), rd, int'(v.rd));
        @(negedge clk);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        chk($sformatf("v%0d busy_after", idx), int'(busy), 0);
        chk($sformatf("v%0d retired_cnt", idx), int'(retired_cnt), exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ret;
        //            op       iw dw lat alu    src rw mr mw be bn m2r  rd
        tbl[0]  = '{4'b0000, 0, 0, 4, 3'b000, 1'b0, 1, 0, 0, 0, 0, 1'b0, 1'b1};
        tbl[1]  = '{4'b0001, 1, 0, 5, 3'b001, 1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 0, 0, 4, 3'b110, 1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{4'b0011, 0, 0, 4, 3'b011, 1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 0, 0, 4, 3'b100, 1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0};
        tbl[5]  = '{4'b0111, 0, 0, 4, 3'b111, 1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0};
        tbl[6]  = '{4'b0101, 0, 0, 3, 3'b010, 1'b0, 0, 0, 0, 1, 0, 1'b0, 1'b0};
        tbl[7]  = '{4'b0110, 0, 0, 3, 3'b010, 1'b0, 0, 0, 0, 0, 1, 1'b0, 1'b0};
        tbl[8]  = '{4'b1000, 0, 3, 8, 3'b001, 1'b1, 1, 4, 0, 0, 0, 1'b1, 1'b0};
        tbl[9]  = '{4'b1001, 0, 0, 4, 3'b001, 1'b1, 0, 0, 1, 0, 0, 1'b0, 1'b0};
        tbl[10] = '{4'b1001, 1, 2, 7, 3'b001, 1'b1, 0, 0, 3, 0, 0, 1'b0, 1'b0};
        tbl[11] = '{4'b1000, 2, 0, 7, 3'b001, 1'b1, 1, 1, 0, 0, 0, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        #12;
        chk("reset strobes", int'(strobes), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset err", int'(err), 0);
        chk("reset cnt", int'(retired_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // Back-to-back R-type with run held high: retires at cycles 4 and 8
        do_reset();
        run = 1'b1; opcode = 4'b0000; imem_ready = 1'b1;
        n_ret = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 8) run = 1'b0;
            #1;
            n_ret += int'(retire);
        end
        @(negedge clk);
        #1;
        chk("b2b retires", n_ret, 2);
        chk("b2b cnt", int'(retired_cnt), 2);
        chk("b2b idle", int'(busy), 0);

        // Illegal opcode goes to ERR after DECODE; sticky while run toggles
        do_reset();
        run = 1'b1; opcode = 4'b1011; imem_ready = 1'b1;
        @(negedge clk);  // FETCH
        @(negedge clk);  // DECODE
        #1;
        chk("illegal not yet err", int'(err), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            run = ~run;
        end
        #1;
        chk("illegal err sticky", int'(err), 1);
        chk("illegal busy", int'(busy), 1);
        chk("illegal strobes", int'(strobes), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst clears err", int'(err), 0);
        chk("rst clears busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // imem_ready low for 16 FETCH cycles -> ERR
        do_reset();
        run = 1'b1; opcode = 4'b0000; imem_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            run = 1'b0;
        end
        #1;
        chk("tmo cycle16 still fetch", int'(imem_req), 1);
        chk("tmo cycle16 err", int'(err), 0);
        @(negedge clk);
        #1;
        chk("tmo err", int'(err), 1);
        chk("tmo imem_req off", int'(imem_req), 0);

        // Ready on exactly the 16th FETCH cycle wins over the timeout
        do_reset();
        run = 1'b1; opcode = 4'b0000; imem_ready = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            run = 1'b0;
        end
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        chk("tmo edge ir_write", int'(ir_write), 1);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        chk("tmo edge no err", int'(err), 0);
        for (int c = 0; c < 3; c++) @(negedge clk);
        #1;
        chk("tmo edge retired", int'(retired_cnt), 1);
        chk("tmo edge idle", int'(busy), 0);

        // rst asserted during MEM clears every output at once
        do_reset();
        run = 1'b1; opcode = 4'b1000; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        #1;
        chk("mem mem_read", int'(mem_read), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst in mem strobes", int'(strobes), 0);
        chk("rst in mem busy", int'(busy), 0);
        @(negedge clk);
        #1;
        chk("rst in mem next edge", int'(strobes), 0);
        chk("rst in mem cnt", int'(retired_cnt), 0);
        run = 1'b0;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
